fp_addsub_iter: RTL
===================

// Module: fp_addsub_iter
// PURPOSE
//  Parametrised IEEE-754 binary add/subtract unit with valid/ready handshakes on input and output.
//  Iterative FSM datapath stages: align, add, normalise one bit per cycle, round-to-nearest-even.
//  Handles specials and reports exception flags; one operation in flight at a time.
//  Sits between the operand issue logic and the FP result writeback in the arithmetic cluster.
// PARAMETERS
//  EXP_W   8   exponent field width (bias = 2^(EXP_W-1)-1)
//  FRAC_W  23  stored fraction width; word width W = 1+EXP_W+FRAC_W
// PORTS
//  clk      in   1  clock; all state changes on rising edge
//  reset    in   1  synchronous, active-high reset
//  iValid   in   1  operands/op valid
//  oReady   out  1  unit can accept (high only in IDLE and reset deasserted)
//  iA       in   W  operand A {sign,exp,frac}
//  iB       in   W  operand B
//  iOp      in   1  0: A+B, 1: A-B (B sign inverted)
//  oValid   out  1  result valid; held until iReady
//  iReady   in   1  downstream accepts result
//  oF       out  W  result
//  oFlags   out  4  {invalid, overflow, underflow, inexact}, valid with oValid
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, oValid=0, oF=0, oFlags=0; aborts any op mid-flight, result discarded.
//  - Accept when iValid&&oReady; iA/iB/iOp captured that edge; inputs ignored otherwise.
//  - FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
//  - ALIGN: unpack; exp==0 operands are zero (denormals flushed to zero, FTZ).
//    Specials go straight to DONE: NaN operand or Inf-Inf (effective sub) -> quiet NaN {0,all1,1,0..0},
//    invalid=1. Any Inf -> that Inf.
//    Otherwise swap so the larger magnitude is X; shift Y right by exponent difference,
//    capped at FRAC_W+3. Shifted-out bits OR into sticky.
//  - Mantissas carried as FRAC_W+4 bits {hidden, frac, G, R, S} plus 1 carry bit.
//  - ADD: effective add if signs(after iOp) equal, else X-Y (never negative); result sign = sign of X.
//  - NORM: on carry, shift right 1 (sticky ORs in) and exp+1, 1 cycle.
//    Else if hidden=0, shift left 1 and exp-1 per cycle until hidden=1.
//    A zero magnitude exits after 1 cycle with +0 (-0 only if both operands -0 on effective add).
//    If exp would drop below 1, flush to signed zero with underflow=1 and inexact=1.
//    NORM occupies >=1 cycle.
//  - ROUND: RNE on G/R/S (round up if G&&(R|S|lsb)); inexact = G|R|S.
//    Mantissa overflow from rounding -> exp+1, frac=0.
//    exp reaching all-ones -> +/-Inf, overflow=1, inexact=1.
//  - DONE: oValid=1, oF/oFlags stable while iValid... while iReady=0.
//    On oValid&&iReady -> IDLE next cycle (oReady reasserts then; no same-cycle accept).
//  - Latency (accept edge to oValid): specials 2 cycles; normal 5 + k cycles, k = left shifts (0..FRAC_W+1).
//  - Exponent arithmetic done in EXP_W+2 bits signed to detect under/overflow; no wrap-around.
// TESTING (default params)
//  1) 0x3F800000 + 0x3F800000, iOp=0 -> oF=0x40000000, oFlags=0, oValid 5 cycles after accept.
//  2) 0x3F800000 - 0x3F7FFFFF (iOp=1) -> 0x33800000, flags=0, oValid 29 cycles after accept (k=24).
//  3) 0x4B800000 + 0x3F800000 -> 0x4B800000 inexact=1 (tie to even); 0x4B800000 + 0x40400000 -> 0x4B800002, inexact=1.
//  4) 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, oFlags=4'b0101; 0x3F800000 - 0x3F800000 -> 0x00000000, flags=0.
//  5) 0x7F800000 - 0x7F800000 -> 0x7FC00000, oFlags=4'b1000, oValid 2 cycles after accept; NaN in -> same qNaN.
//  6) Hold iReady=0 for 10 cycles in DONE -> oF/oFlags stable, oReady=0.
//     Assert reset during NORM -> next cycle oValid=0, oF=0, oReady=1.

Source files
------------

// File: rtl/fp_addsub_iter.sv
// Iterative IEEE-754 add/subtract: align, add, normalise one bit per cycle, round-to-nearest-even.
// Denormal operands are flushed to zero; one operation in flight at a time.
module fp_addsub_iter #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [EXP_W+FRAC_W:0] iA,
    input  logic [EXP_W+FRAC_W:0] iB,
    input  logic                  iOp,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [EXP_W+FRAC_W:0] oF,
    output logic [3:0]            oFlags
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 4;
    localparam int XW = EXP_W + 2;

    localparam logic [EXP_W-1:0]     EXP_ALL1 = '1;
    localparam logic [EXP_W-1:0]     SH_CAP   = EXP_W'(FRAC_W + 3);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ALL1, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]           flags_q, flags_d;
    logic [MW-1:0]        x_mant_q, x_mant_d, y_mant_q, y_mant_d;
    logic [MW:0]          sum_q, sum_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic                 sign_q, sign_d, eff_sub_q, eff_sub_d;

    // Handshakes: an operation is accepted on a rising edge where iValid && oReady;
    // a result is consumed on a rising edge where oValid && iReady. oF/oFlags hold meanwhile.
    assign oReady = (state_q == S_IDLE) && !reset;
    assign oValid = (state_q == S_DONE);
    assign oF     = res_q;
    assign oFlags = flags_q;

    // Operand unpack, swap and alignment (used in ALIGN)
    logic                 a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge, x_sign;
    logic [EXP_W-1:0]     a_exp, b_exp, x_exp, y_exp, diff, shamt;
    logic [FRAC_W-1:0]    a_frac, b_frac;
    logic [W-2:0]         a_mag, b_mag;
    logic [MW-1:0]        a_m, b_m, x_m, y_m, y_sh, lost_mask;

    always_comb begin
        a_sign = a_q[W-1];
        a_exp  = a_q[W-2:FRAC_W];
        a_frac = a_q[FRAC_W-1:0];
        b_sign = b_q[W-1];
        b_exp  = b_q[W-2:FRAC_W];
        b_frac = b_q[FRAC_W-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == EXP_ALL1) && (a_frac == '0);
        b_inf  = (b_exp == EXP_ALL1) && (b_frac == '0);
        a_nan  = (a_exp == EXP_ALL1) && (a_frac != '0);
        b_nan  = (b_exp == EXP_ALL1) && (b_frac != '0);
        a_mag  = a_zero ? '0 : a_q[W-2:0];
        b_mag  = b_zero ? '0 : b_q[W-2:0];
        a_m    = a_zero ? '0 : {1'b1, a_frac, 3'b000};
        b_m    = b_zero ? '0 : {1'b1, b_frac, 3'b000};
        a_ge   = (a_mag >= b_mag);
        if (a_ge) begin
            x_sign = a_sign;
            x_exp  = a_exp;
            x_m    = a_m;
            y_exp  = b_exp;
            y_m    = b_m;
        end else begin
            x_sign = b_sign;
            x_exp  = b_exp;
            x_m    = b_m;
            y_exp  = a_exp;
            y_m    = a_m;
        end
        diff      = x_exp - y_exp;
        shamt     = (diff > SH_CAP) ? SH_CAP : diff;
        lost_mask = ~({MW{1'b1}} << shamt);
        y_sh      = y_m >> shamt;
        y_sh[0]   = y_sh[0] | (|(y_m & lost_mask));
    end

    // Rounding helpers (used in ROUND)
    logic                 round_up, inexact;
    logic [FRAC_W:0]      rnd;
    logic signed [XW-1:0] exp_r;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        flags_d   = flags_q;
        x_mant_d  = x_mant_q;
        y_mant_d  = y_mant_q;
        sum_d     = sum_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        round_up  = 1'b0;
        inexact   = 1'b0;
        rnd       = '0;
        exp_r     = exp_q;

        case (state_q)
            S_IDLE: begin
                if (iValid) begin
                    a_d     = iA;
                    b_d     = {iB[W-1] ^ iOp, iB[W-2:0]};
                    flags_d = '0;
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
                    res_d   = QNAN;
                    flags_d = 4'b1000;
                    state_d = S_DONE;
                end else if (a_inf) begin
                    res_d   = a_q;
                    state_d = S_DONE;
                end else if (b_inf) begin
                    res_d   = b_q;
                    state_d = S_DONE;
                end else begin
                    x_mant_d  = x_m;
                    y_mant_d  = y_sh;
                    exp_d     = $signed({2'b00, x_exp});
                    sign_d    = x_sign;
                    eff_sub_d = a_sign ^ b_sign;
                    state_d   = S_ADD;
                end
            end

            // X has the larger magnitude, so the effective difference never goes negative.
            S_ADD: begin
                if (eff_sub_q) begin
                    sum_d = {1'b0, x_mant_q} - {1'b0, y_mant_q};
                end else begin
                    sum_d = {1'b0, x_mant_q} + {1'b0, y_mant_q};
                end
                state_d = S_NORM;
            end

            S_NORM: begin
                if (sum_q[MW]) begin
                    sum_d   = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else if (sum_q == '0) begin
                    exp_d   = '0;
                    sign_d  = sign_q & ~eff_sub_q;
                    state_d = S_ROUND;
                end else if (sum_q[MW-1]) begin
                    state_d = S_ROUND;
                end else if (exp_q <= EXP_ONE) begin
                    sum_d   = '0;
                    exp_d   = '0;
                    flags_d = flags_q | 4'b0011;
                    state_d = S_ROUND;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EXP_ONE;
                end
            end

            S_ROUND: begin
                round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
                inexact  = |sum_q[2:0];
                rnd      = {1'b0, sum_q[MW-2:3]} + {{FRAC_W{1'b0}}, round_up};
                if (rnd[FRAC_W]) begin
                    exp_r = exp_q + EXP_ONE;
                end
                if (exp_r >= EXP_TOP) begin
                    res_d   = {sign_q, EXP_ALL1, {FRAC_W{1'b0}}};
                    flags_d = flags_q | 4'b0101;
                end else begin
                    res_d   = {sign_q, exp_r[EXP_W-1:0], rnd[FRAC_W-1:0]};
                    flags_d = flags_q | {3'b000, inexact};
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (iReady) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            x_mant_q  <= '0;
            y_mant_q  <= '0;
            sum_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            x_mant_q  <= x_mant_d;
            y_mant_q  <= y_mant_d;
            sum_q     <= sum_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
        end
    end

endmodule
